// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The digit counter needs at least one bit, even when WIDTH == DIGIT.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple adder slice; cmsb is the carry into the slice's top bit.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT:0] full;

    always_comb begin
        full = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
        s    = full[DIGIT-1:0];
        cout = full[DIGIT];
        // Top sum bit is x ^ y ^ carry-in, so the carry-in falls out by XOR.
        cmsb = full[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
    end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: one DIGIT-wide slice per RUN cycle, LSB digit first,
// with a valid/ready handshake on both operand and result sides.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int            NDIG = WIDTH / DIGIT;
    localparam int            CW   = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: DIGIT must be in 1..WIDTH and divide WIDTH");
    end

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              c_out_q, c_out_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;

    int                base;
    logic [DIGIT-1:0]  dig_x, dig_y, dig_s;
    logic              dig_cout, dig_cmsb;

    always_comb begin
        base  = int'(cnt_q) * DIGIT;
        dig_x = a_q[base +: DIGIT];
        dig_y = b_q[base +: DIGIT];
    end

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x    (dig_x),
        .y    (dig_y),
        .cin  (carry_q),
        .s    (dig_s),
        .cout (dig_cout),
        .cmsb (dig_cmsb)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        case (state_q)
            ST_IDLE: begin
                // Subtraction is A + ~B + 1, so c_in is replaced by 1.
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : c_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[base +: DIGIT] = dig_s;
                carry_d              = dig_cout;
                cnt_d                = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    c_out_d     = dig_cout;
                    ovf_d       = dig_cout ^ dig_cmsb;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Operand registers are only read in RUN, after a load, so they need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits processed per RUN cycle; WIDTH mod DIGIT = 0, 1 <= DIGIT <= WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand request.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port c_in  input  1  carry-in; used only when sub=0.
REQ-010 SHALL have port sub  input  1  0: A+B+c_in; 1: A-B.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port c_out  output  1  carry out of MSB (sub=1: 1 means no borrow).
REQ-015 SHALL have port ovf  output  1  two's-complement overflow.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; in_ready = (state==IDLE), combinational from state only.
REQ-017 IDLE: on edge with in_valid&in_ready, SHALL latch a, b^{WIDTH{sub}}, carry = sub ? 1 : c_in, clear digit counter, go RUN.
REQ-018 RUN: each cycle SHALL add digit k (bits k*DIGIT..k*DIGIT+DIGIT-1, LSB digit first) with registered carry, store DIGIT result bits, update carry; k counts 0..WIDTH/DIGIT-1.
REQ-019 After the final digit edge SHALL enter DONE; out_valid high exactly WIDTH/DIGIT cycles after the accepting edge.
REQ-020 c_out SHALL equal carry out of bit WIDTH-1; ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-021 DONE: sum, c_out, ovf, out_valid SHALL hold stable until edge with out_ready=1, then go IDLE (out_valid low, in_ready high next cycle).
REQ-022 in_valid, a, b, c_in, sub SHALL be ignored outside IDLE; no accept in the same cycle as result handoff.
REQ-023 sum/c_out/ovf SHALL retain last result in IDLE until next DONE; values during RUN are don't-care but SHALL not glitch out_valid.
REQ-024 DIGIT==WIDTH SHALL give single RUN cycle (latency 1); arithmetic wraps modulo 2^WIDTH.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counter 0, carry 0, sum 0, c_out 0, ovf 0, out_valid 0, independent of clk.
REQ-026 Reset during RUN or DONE SHALL abandon the operation; no out_valid for it after release.
REQ-027 First accept possible on first rising edge with rst_n high and in_valid high.

Structure
REQ-028 Package adder_pkg SHALL hold FSM state enum and counter-width function (clog2 of WIDTH/DIGIT).
REQ-029 Sub-module digit_adder (parameter DIGIT; inputs x, y, cin; outputs s, cout, cmsb = carry into top bit) SHALL be the only combinational adder, instantiated once.
REQ-030 Parameter legality SHALL be checked at elaboration (error if WIDTH mod DIGIT != 0).

Verification (WIDTH=16, DIGIT=4 unless noted)
REQ-031 a=0xFFFF, b=0x0001, c_in=0, sub=0 -> sum=0x0000, c_out=1, ovf=0, out_valid 4 cycles after accept.
REQ-032 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, c_out=0, ovf=1; a=0x1234, b=0x4321, c_in=1 -> sum=0x5556.
REQ-033 a=0x8000, b=0x0001, sub=1 (c_in=1 driven) -> sum=0x7FFF, c_out=1, ovf=1; a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, c_out=0, ovf=0.
REQ-034 out_ready low 5 cycles in DONE with in_valid toggling and a/b changing -> outputs stable, in_ready 0, no second accept; out_ready high -> IDLE next cycle.
REQ-035 rst_n pulsed low mid-RUN (after 2 digits) -> outputs 0 asynchronously, no out_valid; next operation 0x0001+0x0001 -> 0x0002 normally.
REQ-036 Rerun REQ-031 with DIGIT=16 and DIGIT=1 -> identical results, latency 1 and 16.
